// File: rtl/platform_led_ctrl.sv
// Avalon-MM LED/GPIO output controller: DATA with atomic set/clear, per-bit
// blink enable and a prescaled blink engine whose phase gates the enabled bits.
module platform_led_ctrl #(
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
  parameter int                    PRESCALE_W   = 24,
  parameter logic [PRESCALE_W-1:0] PERIOD_RESET = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
  localparam logic [2:0] ADDR_STATUS   = 3'd6;

  localparam logic [PRESCALE_W-1:0] CNT_RESET =
    (PERIOD_RESET == '0) ? '0 : PERIOD_RESET - 1'b1;

  logic                  r_phase;
  logic [PRESCALE_W-1:0] r_cnt;
  logic [PRESCALE_W-1:0] r_period;
  logic [DATA_WIDTH-1:0] r_blink_en;
  logic [DATA_WIDTH-1:0] r_data;

  logic                  w_wr;
  logic                  w_period_wr;
  logic [DATA_WIDTH-1:0] w_wd_data;
  logic [PRESCALE_W-1:0] w_wd_period;
  logic [PRESCALE_W-1:0] w_cnt_load;
  logic                  w_unused_wd;

  assign w_wr        = chipselect && !write_n;
  assign w_period_wr = w_wr && (address == ADDR_PERIOD);
  assign w_wd_data   = writedata[DATA_WIDTH-1:0];
  assign w_wd_period = writedata[PRESCALE_W-1:0];
  assign w_cnt_load  = (w_wd_period == '0) ? '0 : w_wd_period - 1'b1;
  assign w_unused_wd = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data     <= RESET_VALUE;
      r_blink_en <= '0;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:     r_data     <= w_wd_data;
        ADDR_BLINK_EN: r_blink_en <= w_wd_data;
        ADDR_OUTSET:   r_data     <= r_data | w_wd_data;
        ADDR_OUTCLEAR: r_data     <= r_data & ~w_wd_data;
        default:       ;
      endcase
    end
  end

  // A PERIOD write restarts the engine and wins over a same-cycle expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_period <= PERIOD_RESET;
      r_cnt    <= CNT_RESET;
      r_phase  <= 1'b0;
    end else if (w_period_wr) begin
      r_period <= w_wd_period;
      r_cnt    <= w_cnt_load;
      r_phase  <= 1'b0;
    end else if (r_period == '0) begin
      r_cnt    <= '0;
      r_phase  <= 1'b0;
    end else if (r_cnt == '0) begin
      r_cnt    <= r_period - 1'b1;
      r_phase  <= ~r_phase;
    end else begin
      r_cnt    <= r_cnt - 1'b1;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata[DATA_WIDTH-1:0] = r_data;
      ADDR_BLINK_EN: readdata[DATA_WIDTH-1:0] = r_blink_en;
      ADDR_PERIOD:   readdata[PRESCALE_W-1:0] = r_period;
      ADDR_STATUS:   readdata[0]              = r_phase;
      default:       readdata                 = '0;
    endcase
  end

  assign out_port = r_data & ~(r_blink_en & {DATA_WIDTH{r_phase}});

endmodule
